// File: rtl/exe_stage_pkg.sv
// Shared op codes, divider state encodings and small datapath helpers for the execute stage.
package exe_stage_pkg;

  localparam int DATA_W = 32;

  typedef logic [5:0] aluop_t;

  localparam aluop_t EXE_NOP_OP   = 6'd0;
  localparam aluop_t EXE_AND_OP   = 6'd1;
  localparam aluop_t EXE_OR_OP    = 6'd2;
  localparam aluop_t EXE_XOR_OP   = 6'd3;
  localparam aluop_t EXE_NOR_OP   = 6'd4;
  localparam aluop_t EXE_SLL_OP   = 6'd5;
  localparam aluop_t EXE_SRL_OP   = 6'd6;
  localparam aluop_t EXE_SRA_OP   = 6'd7;
  localparam aluop_t EXE_ADD_OP   = 6'd8;
  localparam aluop_t EXE_ADDU_OP  = 6'd9;
  localparam aluop_t EXE_SUB_OP   = 6'd10;
  localparam aluop_t EXE_SUBU_OP  = 6'd11;
  localparam aluop_t EXE_SLT_OP   = 6'd12;
  localparam aluop_t EXE_SLTU_OP  = 6'd13;
  localparam aluop_t EXE_LUI_OP   = 6'd14;
  localparam aluop_t EXE_MULT_OP  = 6'd15;
  localparam aluop_t EXE_MULTU_OP = 6'd16;
  localparam aluop_t EXE_DIV_OP   = 6'd17;
  localparam aluop_t EXE_DIVU_OP  = 6'd18;
  localparam aluop_t EXE_MFHI_OP  = 6'd19;
  localparam aluop_t EXE_MFLO_OP  = 6'd20;
  localparam aluop_t EXE_MTHI_OP  = 6'd21;
  localparam aluop_t EXE_MTLO_OP  = 6'd22;
  localparam aluop_t EXE_JAL_OP   = 6'd23;
  localparam aluop_t EXE_JALR_OP  = 6'd24;
  localparam aluop_t EXE_LB_OP    = 6'd25;
  localparam aluop_t EXE_LBU_OP   = 6'd26;
  localparam aluop_t EXE_LH_OP    = 6'd27;
  localparam aluop_t EXE_LHU_OP   = 6'd28;
  localparam aluop_t EXE_LW_OP    = 6'd29;
  localparam aluop_t EXE_SB_OP    = 6'd30;
  localparam aluop_t EXE_SH_OP    = 6'd31;
  localparam aluop_t EXE_SW_OP    = 6'd32;

  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;

  localparam logic [0:0] DIV_IDLE = 1'b0;
  localparam logic [0:0] DIV_BUSY = 1'b1;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  // Magnitude of a 32-bit value; 0x8000_0000 maps to itself, which is correct as an unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic signed_en);
    if (signed_en && v[31]) begin
      return 32'd0 - v;
    end else begin
      return v;
    end
  endfunction

  function automatic logic add_ovf(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
    return (a[31] == b[31]) && (r[31] != a[31]);
  endfunction

  function automatic logic sub_ovf(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
    return (a[31] != b[31]) && (r[31] != a[31]);
  endfunction

endpackage

// File: rtl/exe_stage_if.sv
// ID/EXE-side operands in, EXE/MEM-side results out, plus the divider stall request.
interface exe_stage_if;
  logic [5:0]  exe_aluop;
  logic [31:0] exe_pc;
  logic [31:0] exe_inst;
  logic [31:0] exe_reg_1;
  logic [31:0] exe_reg_2;
  logic [4:0]  exe_write_reg;
  logic        exe_we;
  logic [31:0] exe_link_addr;
  logic [5:0]  ex_aluop;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_write_reg;
  logic        ex_we;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_store_data;
  logic        stall_req;

  modport master (
    output exe_aluop, exe_pc, exe_inst, exe_reg_1, exe_reg_2, exe_write_reg, exe_we, exe_link_addr,
    input  ex_aluop, ex_wdata, ex_write_reg, ex_we, ex_mem_addr, ex_store_data, stall_req
  );

  modport slave (
    input  exe_aluop, exe_pc, exe_inst, exe_reg_1, exe_reg_2, exe_write_reg, exe_we, exe_link_addr,
    output ex_aluop, ex_wdata, ex_write_reg, ex_we, ex_mem_addr, ex_store_data, stall_req
  );
endinterface

// File: rtl/exe_stage_div_iter.sv
// 32-step restoring divider on magnitudes; quotient/remainder are sign-fixed and presented during the last step.
module div_iter
  import exe_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [0:0]  state_r;
  logic [4:0]  cnt_r;
  logic [31:0] rem_r;
  logic [31:0] quo_r;
  logic [31:0] dsr_r;
  logic        neg_q_r;
  logic        neg_r_r;

  logic [32:0] shifted_s;
  logic [32:0] trial_s;
  logic [31:0] rem_next_s;
  logic [31:0] quo_next_s;

  // One restoring step: shift in the next dividend bit, subtract the divisor if it fits.
  always_comb begin
    shifted_s = {rem_r, quo_r[31]};
    trial_s   = shifted_s - {1'b0, dsr_r};
    if (shifted_s >= {1'b0, dsr_r}) begin
      rem_next_s = trial_s[31:0];
      quo_next_s = {quo_r[30:0], 1'b1};
    end else begin
      rem_next_s = shifted_s[31:0];
      quo_next_s = {quo_r[30:0], 1'b0};
    end
  end

  assign busy      = (state_r == DIV_BUSY);
  assign done      = busy && (cnt_r == 5'd31);
  assign quotient  = neg_q_r ? (32'd0 - quo_next_s) : quo_next_s;
  assign remainder = neg_r_r ? (32'd0 - rem_next_s) : rem_next_s;

  // Divider FSM, step counter and working registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= DIV_IDLE;
      cnt_r   <= 5'd0;
      rem_r   <= 32'd0;
      quo_r   <= 32'd0;
      dsr_r   <= 32'd0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else begin
      case (state_r)
        DIV_IDLE: begin
          if (start) begin
            state_r <= DIV_BUSY;
            cnt_r   <= 5'd0;
            rem_r   <= 32'd0;
            quo_r   <= abs32(dividend, signed_op);
            dsr_r   <= abs32(divisor, signed_op);
            neg_q_r <= signed_op && (dividend[31] != divisor[31]);
            neg_r_r <= signed_op && dividend[31];
          end else begin
            state_r <= DIV_IDLE;
          end
        end
        DIV_BUSY: begin
          rem_r <= rem_next_s;
          quo_r <= quo_next_s;
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == 5'd31) begin
            state_r <= DIV_IDLE;
          end else begin
            state_r <= DIV_BUSY;
          end
        end
        default: begin
          state_r <= DIV_IDLE;
          cnt_r   <= 5'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU/link mux, memory address, HI/LO registers and the divider stall request.
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int          WIDTH      = 32,
  parameter logic [31:0] DIVZERO_LO = 32'hFFFF_FFFF
)
(
  input  logic        clk,
  input  logic        rst,
  exe_stage_if.slave  bus
);

  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] wdata_s;
  logic             we_s;
  logic signed [63:0] sprod_s;
  logic [63:0]      uprod_s;
  hilo_t            hilo_r;

  logic        is_div_s;
  logic        start_s;
  logic        div_zero_s;
  logic        div_busy_s;
  logic        div_done_s;
  logic [31:0] div_quo_s;
  logic [31:0] div_rem_s;
  logic        unused_s;

  assign a_s     = bus.exe_reg_1;
  assign b_s     = bus.exe_reg_2;
  assign sum_s   = a_s + b_s;
  assign diff_s  = a_s - b_s;
  assign sprod_s = $signed(a_s) * $signed(b_s);
  assign uprod_s = {32'd0, a_s} * {32'd0, b_s};

  assign is_div_s   = (bus.exe_aluop == EXE_DIV_OP) || (bus.exe_aluop == EXE_DIVU_OP);
  assign start_s    = is_div_s && !div_busy_s && (b_s != 32'd0);
  assign div_zero_s = is_div_s && !div_busy_s && (b_s == 32'd0);

  div_iter u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (start_s),
    .signed_op (bus.exe_aluop == EXE_DIV_OP),
    .dividend  (a_s),
    .divisor   (b_s),
    .busy      (div_busy_s),
    .done      (div_done_s),
    .quotient  (div_quo_s),
    .remainder (div_rem_s)
  );

  // Writeback data and final write enable.
  always_comb begin
    wdata_s = ZERO_WORD;
    we_s    = bus.exe_we;
    case (bus.exe_aluop)
      EXE_AND_OP:  wdata_s = a_s & b_s;
      EXE_OR_OP:   wdata_s = a_s | b_s;
      EXE_XOR_OP:  wdata_s = a_s ^ b_s;
      EXE_NOR_OP:  wdata_s = ~(a_s | b_s);
      EXE_SLL_OP:  wdata_s = b_s << a_s[4:0];
      EXE_SRL_OP:  wdata_s = b_s >> a_s[4:0];
      EXE_SRA_OP:  wdata_s = $signed(b_s) >>> a_s[4:0];
      EXE_ADDU_OP: wdata_s = sum_s;
      EXE_SUBU_OP: wdata_s = diff_s;
      EXE_ADD_OP: begin
        wdata_s = sum_s;
        if (add_ovf(a_s, b_s, sum_s)) begin
          we_s = WRITE_DISABLE;
        end else begin
          we_s = bus.exe_we;
        end
      end
      EXE_SUB_OP: begin
        wdata_s = diff_s;
        if (sub_ovf(a_s, b_s, diff_s)) begin
          we_s = WRITE_DISABLE;
        end else begin
          we_s = bus.exe_we;
        end
      end
      EXE_SLT_OP:  wdata_s = {31'd0, ($signed(a_s) < $signed(b_s))};
      EXE_SLTU_OP: wdata_s = {31'd0, (a_s < b_s)};
      EXE_LUI_OP:  wdata_s = b_s;
      EXE_JAL_OP, EXE_JALR_OP: wdata_s = bus.exe_link_addr;
      EXE_MFHI_OP: wdata_s = hilo_r.hi;
      EXE_MFLO_OP: wdata_s = hilo_r.lo;
      EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP, EXE_DIVU_OP, EXE_MTHI_OP, EXE_MTLO_OP:
        we_s = WRITE_DISABLE;
      EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP:
        wdata_s = ZERO_WORD;
      default: begin
        wdata_s = ZERO_WORD;
        we_s    = WRITE_DISABLE;
      end
    endcase
  end

  // HI/LO: divider completion outranks any same-cycle MULT/MTHI/MTLO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hilo_r <= '{hi: 32'd0, lo: 32'd0};
    end else if (div_done_s) begin
      hilo_r <= '{hi: div_rem_s, lo: div_quo_s};
    end else if (div_zero_s) begin
      hilo_r <= '{hi: a_s, lo: DIVZERO_LO};
    end else begin
      case (bus.exe_aluop)
        EXE_MULT_OP:  hilo_r <= sprod_s;
        EXE_MULTU_OP: hilo_r <= uprod_s;
        EXE_MTHI_OP:  hilo_r.hi <= a_s;
        EXE_MTLO_OP:  hilo_r.lo <= a_s;
        default:      hilo_r <= hilo_r;
      endcase
    end
  end

  assign bus.ex_aluop      = bus.exe_aluop;
  assign bus.ex_wdata      = wdata_s;
  assign bus.ex_write_reg  = bus.exe_write_reg;
  assign bus.ex_we         = we_s;
  assign bus.ex_mem_addr   = a_s + sext16(bus.exe_inst[15:0]);
  assign bus.ex_store_data = b_s;
  assign bus.stall_req     = rst && (start_s || div_busy_s);

  assign unused_s = ^{bus.exe_pc, bus.exe_inst[31:16]};

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: ALU, overflow, HI/LO via MULT/MT*, divider latency, divide-by-zero and reset mid-divide.
module tb_exe_stage;
  import exe_stage_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  exe_stage_if bus ();

  exe_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_op(input aluop_t op, input logic [31:0] a, input logic [31:0] b);
    bus.exe_aluop     = op;
    bus.exe_reg_1     = a;
    bus.exe_reg_2     = b;
    bus.exe_we        = 1'b1;
    bus.exe_inst      = 32'h0000_0000;
    bus.exe_pc        = 32'h0000_0400;
    bus.exe_write_reg = 5'd3;
    bus.exe_link_addr = 32'h0000_0408;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input aluop_t op, input logic [31:0] a, input logic [31:0] b, output int cyc);
    set_op(op, a, b);
    #1;
    cyc = 0;
    while (bus.stall_req === 1'b1 && cyc < 100) begin
      cyc++;
      next_cycle();
      set_op(EXE_NOP_OP, 32'd0, 32'd0);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_op(EXE_MFHI_OP, 32'd0, 32'd0);
    #1;
    checks++;
    if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", bus.stall_req); end
    checks++;
    if (bus.ex_wdata !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", bus.ex_wdata); end
    set_op(EXE_MFLO_OP, 32'd0, 32'd0);
    #1;
    checks++;
    if (bus.ex_wdata !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", bus.ex_wdata); end
    next_cycle();
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_add_sub();
    set_op(EXE_ADD_OP, 32'h7FFF_FFFF, 32'h0000_0001);
    #1;
    checks++;
    if (bus.ex_wdata !== 32'h8000_0000) begin errors++; $display("FAIL add_ovf_data got %h want 80000000", bus.ex_wdata); end
    checks++;
    if (bus.ex_we !== 1'b0) begin errors++; $display("FAIL add_ovf_we got %b want 0", bus.ex_we); end
    set_op(EXE_ADDU_OP, 32'h7FFF_FFFF, 32'h0000_0001);
    #1;
    checks++;
    if (bus.ex_wdata !== 32'h8000_0000) begin errors++; $display("FAIL addu_data got %h want 80000000", bus.ex_wdata); end
    checks++;
    if (bus.ex_we !== 1'b1) begin errors++; $display("FAIL addu_we got %b want 1", bus.ex_we); end
    set_op(EXE_SUB_OP, 32'h8000_0000, 32'h0000_0001);
    #1;
    checks++;
    if (bus.ex_wdata !== 32'h7FFF_FFFF || bus.ex_we !== 1'b0) begin
      errors++; $display("FAIL sub_ovf got %h/%b want 7fffffff/0", bus.ex_wdata, bus.ex_we);
    end
    set_op(EXE_SUB_OP, 32'h0000_0005, 32'h0000_0007);
    #1;
    checks++;
    if (bus.ex_wdata !== 32'hFFFF_FFFE || bus.ex_we !== 1'b1) begin
      errors++; $display("FAIL sub_plain got %h/%b want fffffffe/1", bus.ex_wdata, bus.ex_we);
    end
    set_op(EXE_SW_OP, 32'h0000_1000, 32'hDEAD_BEEF);
    bus.exe_we   = 1'b0;
    bus.exe_inst = 32'hAC00_FFFC;
    #1;
    checks++;
    if (bus.ex_mem_addr !== 32'h0000_0FFC) begin errors++; $display("FAIL mem_addr got %h want 00000ffc", bus.ex_mem_addr); end
    checks++;
    if (bus.ex_store_data !== 32'hDEAD_BEEF || bus.ex_wdata !== 32'h0) begin
      errors++; $display("FAIL store got %h/%h want deadbeef/0", bus.ex_store_data, bus.ex_wdata);
    end
    set_op(EXE_JAL_OP, 32'h0, 32'h0);
    #1;
    checks++;
    if (bus.ex_wdata !== 32'h0000_0408 || bus.ex_write_reg !== 5'd3 || bus.ex_aluop !== EXE_JAL_OP) begin
      errors++; $display("FAIL jal got %h/%0d want 00000408/3", bus.ex_wdata, bus.ex_write_reg);
    end
  endtask

  task automatic test_logic_shift();
    set_op(EXE_AND_OP, 32'hF0F0_1234, 32'h0FF0_FF00);
    #1;
    checks++;
    if (bus.ex_wdata !== 32'h00F0_1200) begin errors++; $display("FAIL and got %h want 00f01200", bus.ex_wdata); end
    set_op(EXE_NOR_OP, 32'hF0F0_0000, 32'h0000_000F);
    #1;
    checks++;
    if (bus.ex_wdata !== 32'h0F0F_FFF0) begin errors++; $display("FAIL nor got %h want 0f0ffff0", bus.ex_wdata); end
    set_op(EXE_SRA_OP, 32'h0000_0004, 32'h8000_00F0);
    #1;
    checks++;
    if (bus.ex_wdata !== 32'hF800_000F) begin errors++; $display("FAIL sra got %h want f800000f", bus.ex_wdata); end
    set_op(EXE_SRL_OP, 32'h0000_0004, 32'h8000_00F0);
    #1;
    checks++;
    if (bus.ex_wdata !== 32'h0800_000F) begin errors++; $display("FAIL srl got %h want 0800000f", bus.ex_wdata); end
    set_op(EXE_SLTU_OP, 32'h0000_0001, 32'hFFFF_FFFF);
    #1;
    checks++;
    if (bus.ex_wdata !== 32'h1) begin errors++; $display("FAIL sltu got %h want 1", bus.ex_wdata); end
    set_op(EXE_SLT_OP, 32'h0000_0001, 32'hFFFF_FFFF);
    #1;
    checks++;
    if (bus.ex_wdata !== 32'h0) begin errors++; $display("FAIL slt got %h want 0", bus.ex_wdata); end
    set_op(6'd63, 32'h1234_5678, 32'h1111_1111);
    #1;
    checks++;
    if (bus.ex_wdata !== 32'h0 || bus.ex_we !== 1'b0) begin
      errors++; $display("FAIL unknown_op got %h/%b want 0/0", bus.ex_wdata, bus.ex_we);
    end
  endtask

  task automatic test_mult();
    set_op(EXE_MULT_OP, 32'hFFFF_FFFF, 32'h0000_0002);
    #1;
    checks++;
    if (bus.ex_we !== 1'b0) begin errors++; $display("FAIL mult_we got %b want 0", bus.ex_we); end
    next_cycle();
    set_op(EXE_MFHI_OP, 32'd0, 32'd0);
    #1;
    checks++;
    if (bus.ex_wdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", bus.ex_wdata); end
    next_cycle();
    set_op(EXE_MFLO_OP, 32'd0, 32'd0);
    #1;
    checks++;
    if (bus.ex_wdata !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mult_lo got %h want fffffffe", bus.ex_wdata); end
    set_op(EXE_MULTU_OP, 32'hFFFF_FFFF, 32'h0000_0002);
    next_cycle();
    set_op(EXE_MFHI_OP, 32'd0, 32'd0);
    #1;
    checks++;
    if (bus.ex_wdata !== 32'h0000_0001) begin errors++; $display("FAIL multu_hi got %h want 1", bus.ex_wdata); end
    set_op(EXE_MFLO_OP, 32'd0, 32'd0);
    #1;
    checks++;
    if (bus.ex_wdata !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_lo got %h want fffffffe", bus.ex_wdata); end
    set_op(EXE_MTHI_OP, 32'hCAFE_0001, 32'd0);
    next_cycle();
    set_op(EXE_MFHI_OP, 32'd0, 32'd0);
    #1;
    checks++;
    if (bus.ex_wdata !== 32'hCAFE_0001) begin errors++; $display("FAIL mthi got %h want cafe0001", bus.ex_wdata); end
    next_cycle();
  endtask

  task automatic check_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    set_op(EXE_MFLO_OP, 32'd0, 32'd0);
    #1;
    checks++;
    if (bus.ex_wdata !== exp_lo) begin errors++; $display("FAIL %s_lo got %h want %h", tag, bus.ex_wdata, exp_lo); end
    set_op(EXE_MFHI_OP, 32'd0, 32'd0);
    #1;
    checks++;
    if (bus.ex_wdata !== exp_hi) begin errors++; $display("FAIL %s_hi got %h want %h", tag, bus.ex_wdata, exp_hi); end
  endtask

  task automatic test_div();
    int cyc;
    run_div(EXE_DIV_OP, 32'hFFFF_FFF9, 32'h0000_0002, cyc);
    checks++;
    if (cyc != 33) begin errors++; $display("FAIL div_stall_len got %0d want 33", cyc); end
    check_hilo("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    next_cycle();
    run_div(EXE_DIVU_OP, 32'd100, 32'd7, cyc);
    checks++;
    if (cyc != 33) begin errors++; $display("FAIL divu_stall_len got %0d want 33", cyc); end
    check_hilo("divu_100_7", 32'd2, 32'd14);
    next_cycle();
    run_div(EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    check_hilo("div_min_m1", 32'h0, 32'h8000_0000);
    next_cycle();
    run_div(EXE_DIV_OP, 32'h0000_0007, 32'hFFFF_FFFE, cyc);
    check_hilo("div_7_m2", 32'h0000_0001, 32'hFFFF_FFFD);
    next_cycle();
  endtask

  task automatic test_div_zero();
    set_op(EXE_DIV_OP, 32'd5, 32'd0);
    #1;
    checks++;
    if (bus.stall_req !== 1'b0 || bus.ex_we !== 1'b0) begin
      errors++; $display("FAIL divzero_stall got %b/%b want 0/0", bus.stall_req, bus.ex_we);
    end
    next_cycle();
    set_op(EXE_NOP_OP, 32'd0, 32'd0);
    #1;
    checks++;
    if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL divzero_stall_after got %b want 0", bus.stall_req); end
    check_hilo("divzero", 32'd5, 32'hFFFF_FFFF);
    next_cycle();
  endtask

  task automatic test_reset_mid_div();
    int cyc;
    set_op(EXE_DIV_OP, 32'hFFFF_FFF9, 32'h0000_0002);
    next_cycle();
    set_op(EXE_NOP_OP, 32'd0, 32'd0);
    repeat (10) next_cycle();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL rst_mid_stall got %b want 0", bus.stall_req); end
    check_hilo("rst_mid", 32'h0, 32'h0);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    run_div(EXE_DIVU_OP, 32'd100, 32'd7, cyc);
    checks++;
    if (cyc != 33) begin errors++; $display("FAIL post_rst_stall_len got %0d want 33", cyc); end
    check_hilo("post_rst_divu", 32'd2, 32'd14);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    set_op(EXE_NOP_OP, 32'd0, 32'd0);
    test_reset();
    test_add_sub();
    test_logic_shift();
    test_mult();
    test_div_zero();
    test_div();
    test_div_zero();
    test_reset_mid_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
